// File: rtl/serial_adder_sub.sv
// rtl/serial_adder_sub.sv - bit-serial add/subtract unit, LSB first, one bit per clock
module serial_adder_sub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] Data_in_A,
    input  logic [WIDTH-1:0] Data_in_B,
    input  logic             Data_in_C,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Data_out_Sum,
    output logic             Data_out_Carry,
    output logic             Data_out_Overflow
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-2:0] res_reg;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic             sum_bit;
    logic             carry_next;
    logic             last_bit;
    logic [WIDTH-1:0] res_shift;

    assign sum_bit    = a_reg[0] ^ b_reg[0] ^ carry;
    assign carry_next = (a_reg[0] & b_reg[0]) | (carry & (a_reg[0] ^ b_reg[0]));
    assign last_bit   = (cnt == CW'(WIDTH - 1));
    // Sum bits enter from the MSB side so that after WIDTH shifts bit 0 sits at the LSB.
    assign res_shift  = {sum_bit, res_reg};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_bit) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg             <= '0;
            b_reg             <= '0;
            res_reg           <= '0;
            carry             <= 1'b0;
            cnt               <= '0;
            Data_out_Sum      <= '0;
            Data_out_Carry    <= 1'b0;
            Data_out_Overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        // Subtraction is A + ~B + ~borrow, so the carry-out reads as "no borrow".
                        a_reg <= Data_in_A;
                        b_reg <= mode ? ~Data_in_B : Data_in_B;
                        carry <= Data_in_C ^ mode;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    a_reg   <= a_reg >> 1;
                    b_reg   <= b_reg >> 1;
                    carry   <= carry_next;
                    res_reg <= res_shift[WIDTH-1:1];
                    if (last_bit) begin
                        Data_out_Sum      <= res_shift;
                        Data_out_Carry    <= carry_next;
                        Data_out_Overflow <= carry ^ carry_next;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_adder_sub.sv
// tb/tb_serial_adder_sub.sv - self-checking bench for serial_adder_sub against an arithmetic model
module tb_serial_adder_sub;
    logic       clk;
    logic       rst_n;
    logic       start;
    logic       mode;
    logic [7:0] Data_in_A;
    logic [7:0] Data_in_B;
    logic       Data_in_C;
    logic       busy;
    logic       done;
    logic [7:0] Data_out_Sum;
    logic       Data_out_Carry;
    logic       Data_out_Overflow;

    int checks;
    int errors;

    logic [7:0] last_sum;
    logic       last_carry;
    logic       last_ovf;

    serial_adder_sub #(.WIDTH(8)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .mode             (mode),
        .Data_in_A        (Data_in_A),
        .Data_in_B        (Data_in_B),
        .Data_in_C        (Data_in_C),
        .busy             (busy),
        .done             (done),
        .Data_out_Sum     (Data_out_Sum),
        .Data_out_Carry   (Data_out_Carry),
        .Data_out_Overflow(Data_out_Overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operands.
    task automatic model(input logic [7:0] a, input logic [7:0] b, input logic c, input logic m,
                         output logic [7:0] sum, output logic cy, output logic ovf);
        int ua, ub, sa, sb, r, sr;
        ua = int'(a);
        ub = int'(b);
        sa = (ua >= 128) ? ua - 256 : ua;
        sb = (ub >= 128) ? ub - 256 : ub;
        if (!m) begin
            r   = ua + ub + int'(c);
            sum = r[7:0];
            cy  = (r >= 256);
            sr  = sa + sb + int'(c);
        end else begin
            r   = ua - ub - int'(c);
            sum = r[7:0];
            cy  = (ua >= ub + int'(c));
            sr  = sa - sb - int'(c);
        end
        ovf = (sr > 127) || (sr < -128);
    endtask

    // Called at a falling edge; returns at a falling edge after the DUT is back in IDLE.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic c, input logic m,
                          input bit scramble);
        logic [7:0] esum;
        logic       ecy;
        logic       eovf;
        int         cycles;
        int         busy_cnt;
        bit         got;
        model(a, b, c, m, esum, ecy, eovf);
        Data_in_A = a;
        Data_in_B = b;
        Data_in_C = c;
        mode      = m;
        start     = 1'b1;
        @(posedge clk);
        cycles   = 0;
        busy_cnt = 0;
        got      = 0;
        while (!got && cycles < 20) begin
            @(negedge clk);
            cycles++;
            if (busy) busy_cnt++;
            if (done) begin
                got = 1;
            end else begin
                check("hold_sum", Data_out_Sum, last_sum);
                check("hold_carry", Data_out_Carry, last_carry);
                if (scramble) begin
                    start     = 1'($urandom);
                    mode      = 1'($urandom);
                    Data_in_A = 8'($urandom);
                    Data_in_B = 8'($urandom);
                    Data_in_C = 1'($urandom);
                end else begin
                    start = 1'b0;
                end
            end
        end
        check("done_edges_after_start", cycles - 1, 8);
        check("busy_cycles", busy_cnt, 9);
        check("sum", Data_out_Sum, esum);
        check("carry", Data_out_Carry, ecy);
        check("overflow", Data_out_Overflow, eovf);
        last_sum   = esum;
        last_carry = ecy;
        last_ovf   = eovf;
        start = scramble ? 1'b1 : 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("idle_after_done", busy, 0);
        check("single_done", done, 0);
    endtask

    initial begin
        logic [7:0] qa[6];
        logic [7:0] qb[6];
        logic       qc[6];
        logic       qm[6];
        logic [7:0] esum;
        logic       ecy;
        logic       eovf;
        int         dcount;

        checks = 0;
        errors = 0;
        last_sum = 8'h00;
        last_carry = 1'b0;
        last_ovf = 1'b0;
        start = 1'b0;
        mode = 1'b0;
        Data_in_A = 8'h00;
        Data_in_B = 8'h00;
        Data_in_C = 1'b0;
        rst_n = 1'b0;

        #3;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_sum", Data_out_Sum, 0);
        check("reset_carry", Data_out_Carry, 0);
        check("reset_ovf", Data_out_Overflow, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases; the first start is sampled on the first edge after reset release.
        run_op(8'h0F, 8'h01, 1'b0, 1'b0, 0);
        run_op(8'hFF, 8'h01, 1'b1, 1'b0, 0);
        run_op(8'h7F, 8'h01, 1'b0, 1'b0, 0);
        run_op(8'h05, 8'h07, 1'b0, 1'b1, 0);
        run_op(8'h80, 8'h01, 1'b0, 1'b1, 0);
        run_op(8'h00, 8'h00, 1'b1, 1'b1, 0);
        run_op(8'hFF, 8'hFF, 1'b1, 1'b0, 0);

        // Inputs churn while busy, including a start held through DONE.
        run_op(8'h3C, 8'hA5, 1'b1, 1'b0, 1);
        run_op(8'h12, 8'h34, 1'b1, 1'b1, 1);

        for (int i = 0; i < 20; i++) begin
            run_op(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), (i % 3) == 0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Asynchronous reset between edges in the middle of RUN.
        run_op(8'hC3, 8'h5A, 1'b0, 1'b0, 0);
        Data_in_A = 8'h11;
        Data_in_B = 8'h22;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_busy", busy, 0);
        check("async_rst_done", done, 0);
        check("async_rst_sum", Data_out_Sum, 0);
        check("async_rst_carry", Data_out_Carry, 0);
        check("async_rst_ovf", Data_out_Overflow, 0);
        last_sum = 8'h00;
        last_carry = 1'b0;
        last_ovf = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        dcount = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) dcount++;
        end
        check("no_done_after_abort", dcount, 0);
        run_op(8'h9A, 8'h0B, 1'b1, 1'b1, 0);

        // Back-to-back with start held high: one result every 10 cycles.
        for (int k = 0; k < 6; k++) begin
            qa[k] = 8'($urandom);
            qb[k] = 8'($urandom);
            qc[k] = 1'($urandom);
            qm[k] = 1'($urandom);
        end
        Data_in_A = qa[0];
        Data_in_B = qb[0];
        Data_in_C = qc[0];
        mode = qm[0];
        start = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                check("b2b_done_timing", done, (i == 8) ? 1 : 0);
                if (i == 0) begin
                    Data_in_A = qa[k+1];
                    Data_in_B = qb[k+1];
                    Data_in_C = qc[k+1];
                    mode = qm[k+1];
                end
                if (i == 8) begin
                    model(qa[k], qb[k], qc[k], qm[k], esum, ecy, eovf);
                    check("b2b_sum", Data_out_Sum, esum);
                    check("b2b_carry", Data_out_Carry, ecy);
                    check("b2b_ovf", Data_out_Overflow, eovf);
                end
            end
        end
        start = 1'b0;
        repeat (12) @(negedge clk);
        check("b2b_end_idle", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/serial_adder_sub.md
SERIAL_ADDER_SUB -- requirements
Module: serial_adder_sub

Interface
REQ-001 Parameter: WIDTH, default 8, operand width in bits; the block SHALL support any WIDTH >= 2.
REQ-002 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: start  input  1  request a new operation; sampled only in IDLE.
REQ-005 Port: mode  input  1  operation select: 0 = add, 1 = subtract (A - B).
REQ-006 Port: Data_in_A  input  WIDTH  operand A.
REQ-007 Port: Data_in_B  input  WIDTH  operand B.
REQ-008 Port: Data_in_C  input  1  carry-in for add; borrow-in for subtract.
REQ-009 Port: busy  output  1  high while an operation is in progress (RUN or DONE).
REQ-010 Port: done  output  1  one-cycle pulse marking a valid new result.
REQ-011 Port: Data_out_Sum  output  WIDTH  registered result.
REQ-012 Port: Data_out_Carry  output  1  final carry-out; for subtract, 1 = no borrow.
REQ-013 Port: Data_out_Overflow  output  1  two's-complement signed overflow of the result.

Function
REQ-014 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-015 IDLE with start=1 at an edge SHALL:
- latch A;
- latch B, bitwise inverted when mode=1;
- set the carry flip-flop to Data_in_C (mode=0) or ~Data_in_C (mode=1);
- clear the bit counter;
- enter RUN.
REQ-016 In RUN, each edge SHALL process one bit, LSB first, using full-adder logic:
- sum bit = a ^ b ^ c;
- carry = (a & b) | (c & (a ^ b));
- the sum bit is shifted into the internal result register from the MSB side;
- the counter increments.
REQ-017 On the edge that processes bit WIDTH-1, the block SHALL:
- load Data_out_Sum and Data_out_Carry;
- load Data_out_Overflow = (carry into MSB) ^ (carry out of MSB);
- enter DONE.
REQ-018 Latency: done SHALL be high during exactly the cycle following the WIDTH-th edge after the edge that sampled start.
REQ-019 DONE SHALL last one cycle, then return to IDLE; a start present in that same cycle is ignored.
REQ-020 start, mode, Data_in_A, Data_in_B and Data_in_C SHALL be ignored while busy=1; a changing operand mid-operation does not affect the result.
REQ-021 Back-to-back operation: start sampled on the first IDLE edge after DONE SHALL begin a new operation, giving a throughput of one result per WIDTH+2 cycles.
REQ-022 Data_out_Sum, Data_out_Carry and Data_out_Overflow SHALL hold their last values until the next DONE entry; they SHALL NOT change during RUN.
REQ-023 Results SHALL equal:
- add: {Carry, Sum} = A + B + C modulo 2^(WIDTH+1);
- subtract: Sum = (A - B - C) mod 2^WIDTH, with Carry = 1 exactly when A >= B + C (unsigned).
REQ-024 The bit counter SHALL be ceil(log2(WIDTH)) bits wide minimum and SHALL never wrap inside RUN.

Reset
REQ-025 rst_n=0 SHALL immediately, without waiting for a clock edge:
- force IDLE;
- clear busy, done, the counter, the carry flip-flop, Data_out_Sum, Data_out_Carry and Data_out_Overflow to 0.
REQ-026 Reset asserted during RUN or DONE SHALL abort the operation: no done pulse is produced and the outputs read 0.
REQ-027 After rst_n deasserts, the first rising edge SHALL be able to sample start normally.

Verification (WIDTH=8)
REQ-028 Add 8'h0F + 8'h01, C=0 -> Sum=8'h10, Carry=0, Overflow=0; done exactly 8 edges after the start edge; busy high for 9 cycles.
REQ-029 Add 8'hFF + 8'h01, C=1 -> Sum=8'h01, Carry=1, Overflow=0; add 8'h7F + 8'h01, C=0 -> Sum=8'h80, Carry=0, Overflow=1.
REQ-030 Subtract 8'h05 - 8'h07, C=0 -> Sum=8'hFE, Carry=0, Overflow=0; subtract 8'h80 - 8'h01, C=0 -> Sum=8'h7F, Carry=1, Overflow=1.
REQ-031 Start pulsed and operands changed during RUN -> ignored; result matches the originally latched operands; a single done pulse.
REQ-032 rst_n pulled low asynchronously mid-RUN (between edges) -> busy and all outputs 0 immediately; no done; next start gives a correct result.
REQ-033 Back-to-back starts held high continuously -> one done per 10 cycles; each result correct for the operands present at its start edge.
